// File: rtl/fpu_core_arbiter.sv
// rtl/fpu_core_arbiter.sv - round-robin NB_CORES-to-one FPU front end with in-order response routing
// Optional macro FPU_ARB_ERR_CHECK_EN: drop unexpected responses and raise a sticky err_o.
module fpu_core_arbiter #(
    parameter int NB_CORES      = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int NB_ARGS       = 3,
    parameter int OPCODE_WIDTH  = 6,
    parameter int DSFLAGS_WIDTH = 15,
    parameter int USFLAGS_WIDTH = 5,
    parameter int MAX_INFLIGHT  = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NB_CORES-1:0]                            core_req_i,
    output logic [NB_CORES-1:0]                            core_gnt_o,
    input  logic [NB_CORES-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0] core_operands_i,
    input  logic [NB_CORES-1:0][OPCODE_WIDTH-1:0]          core_op_i,
    input  logic [NB_CORES-1:0][DSFLAGS_WIDTH-1:0]         core_flags_i,
    input  logic [NB_CORES-1:0]                            core_rready_i,
    output logic [NB_CORES-1:0]                            core_rvalid_o,
    output logic [DATA_WIDTH-1:0]                          core_rdata_o,
    output logic [USFLAGS_WIDTH-1:0]                       core_rflags_o,
    output logic                                           fpu_req_o,
    input  logic                                           fpu_gnt_i,
    output logic [NB_ARGS-1:0][DATA_WIDTH-1:0]             fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]                        fpu_op_o,
    output logic [DSFLAGS_WIDTH-1:0]                       fpu_flags_o,
    output logic                                           fpu_rready_o,
    input  logic                                           fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                          fpu_rdata_i,
    input  logic [USFLAGS_WIDTH-1:0]                       fpu_rflags_i,
    output logic                                           err_o
);
    localparam int IDW = $clog2(NB_CORES);
    localparam int PW  = $clog2(MAX_INFLIGHT);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] locked_idx;
    logic           lock;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] id_fifo [MAX_INFLIGHT];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [PW:0]    count;
    logic           blocked;
    logic           hs;
    logic           have_head;
    logic [IDW-1:0] head;
    logic           rsp;
    logic           push;
    logic           pop;

    // Round-robin search from rr_ptr; a locked (offered but ungranted) request keeps its slot.
    always_comb begin
        int       idx;
        logic     found;
        logic [IDW-1:0] cand;
        winner = rr_ptr;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        if (lock) begin
            winner = locked_idx;
        end else begin
            for (int k = 0; k < NB_CORES; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NB_CORES) idx = idx - NB_CORES;
                cand = IDW'(idx);
                if (!found && core_req_i[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    assign blocked        = (count == (PW+1)'(MAX_INFLIGHT));
    assign fpu_req_o      = (|core_req_i) && !blocked;
    assign hs             = fpu_req_o && fpu_gnt_i;
    assign fpu_operands_o = core_operands_i[winner];
    assign fpu_op_o       = core_op_i[winner];
    assign fpu_flags_o    = core_flags_i[winner];
    assign core_rdata_o   = fpu_rdata_i;
    assign core_rflags_o  = fpu_rflags_i;

    always_comb begin
        core_gnt_o = '0;
        if (hs) core_gnt_o[winner] = 1'b1;
    end

    // With an empty FIFO, the op being granted this cycle can receive its response in the same cycle.
    always_comb begin
        have_head     = 1'b0;
        head          = '0;
        core_rvalid_o = '0;
        fpu_rready_o  = 1'b0;
        if (count != '0) begin
            have_head = 1'b1;
            head      = id_fifo[rd_ptr];
        end else if (hs) begin
            have_head = 1'b1;
            head      = winner;
        end
        if (have_head) begin
            core_rvalid_o[head] = fpu_rvalid_i;
            fpu_rready_o        = core_rready_i[head];
        end else begin
`ifdef FPU_ARB_ERR_CHECK_EN
            fpu_rready_o = fpu_rvalid_i;
`endif
        end
    end

    assign rsp  = fpu_rvalid_i && fpu_rready_o && have_head;
    assign pop  = rsp && (count != '0);
    assign push = hs && !(rsp && (count == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            lock       <= 1'b0;
            locked_idx <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            if (hs) begin
                rr_ptr <= (winner == IDW'(NB_CORES - 1)) ? '0 : winner + IDW'(1);
                lock   <= 1'b0;
            end else if (fpu_req_o) begin
                lock       <= 1'b1;
                locked_idx <= winner;
            end
            if (push) begin
                id_fifo[wr_ptr] <= winner;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FPU_ARB_ERR_CHECK_EN
    logic err;
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((fpu_rvalid_i && !have_head) || (lock && !core_req_i[locked_idx])) begin
            err <= 1'b1;
        end
    end
    assign err_o = err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_core_arbiter.sv
// tb/tb_fpu_core_arbiter.sv - self-checking bench for fpu_core_arbiter
module tb_fpu_core_arbiter;
    localparam int NC = 4;
    localparam int DW = 32;
    localparam int NA = 3;
    localparam int OW = 6;
    localparam int FW = 15;
    localparam int UW = 5;
    localparam int MI = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NC-1:0]                core_req;
    logic [NC-1:0]                core_gnt;
    logic [NC-1:0][NA-1:0][DW-1:0] core_operands;
    logic [NC-1:0][OW-1:0]        core_op;
    logic [NC-1:0][FW-1:0]        core_flags;
    logic [NC-1:0]                core_rready;
    logic [NC-1:0]                core_rvalid;
    logic [DW-1:0]                core_rdata;
    logic [UW-1:0]                core_rflags;
    logic                         fpu_req;
    logic                         fpu_gnt;
    logic [NA-1:0][DW-1:0]        fpu_operands;
    logic [OW-1:0]                fpu_op;
    logic [FW-1:0]                fpu_flags;
    logic                         fpu_rready;
    logic                         fpu_rvalid;
    logic [DW-1:0]                fpu_rdata;
    logic [UW-1:0]                fpu_rflags;
    logic                         err;

    fpu_core_arbiter #(
        .NB_CORES(NC), .DATA_WIDTH(DW), .NB_ARGS(NA), .OPCODE_WIDTH(OW),
        .DSFLAGS_WIDTH(FW), .USFLAGS_WIDTH(UW), .MAX_INFLIGHT(MI)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req_i(core_req), .core_gnt_o(core_gnt),
        .core_operands_i(core_operands), .core_op_i(core_op), .core_flags_i(core_flags),
        .core_rready_i(core_rready), .core_rvalid_o(core_rvalid),
        .core_rdata_o(core_rdata), .core_rflags_o(core_rflags),
        .fpu_req_o(fpu_req), .fpu_gnt_i(fpu_gnt),
        .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_flags_o(fpu_flags),
        .fpu_rready_o(fpu_rready), .fpu_rvalid_i(fpu_rvalid),
        .fpu_rdata_i(fpu_rdata), .fpu_rflags_i(fpu_rflags),
        .err_o(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: next round-robin start, pending (offered, ungranted) core, queue of in-flight core IDs.
    int m_rr;
    int m_pend;
    int m_q[$];
    logic          e_req;
    logic          e_hs;
    logic          e_rready;
    int            e_win;
    int            e_head;
    logic [NC-1:0] e_gnt;
    logic [NC-1:0] e_rvalid;

    task automatic model_eval();
        e_win = -1;
        if (m_pend >= 0) e_win = m_pend;
        else
            for (int k = 0; k < NC; k++)
                if (e_win < 0 && core_req[IW'((m_rr + k) % NC)]) e_win = (m_rr + k) % NC;
        e_req  = (core_req != '0) && (m_q.size() < MI);
        e_hs   = e_req && fpu_gnt;
        e_gnt  = e_hs ? (NC'(1) << e_win) : '0;
        e_head = (m_q.size() > 0) ? m_q[0] : (e_hs ? e_win : -1);
        e_rvalid = '0;
        e_rready = 1'b0;
        if (e_head >= 0) begin
            e_rvalid = fpu_rvalid ? (NC'(1) << e_head) : '0;
            e_rready = core_rready[IW'(e_head)];
        end
    endtask

    task automatic model_commit();
        logic rsp;
        int   qs;
        qs  = m_q.size();
        rsp = fpu_rvalid && (e_head >= 0) && e_rready;
        if (e_hs) begin
            m_rr   = (e_win + 1) % NC;
            m_pend = -1;
        end else if (e_req) begin
            m_pend = e_win;
        end
        if (rsp && qs > 0) void'(m_q.pop_front());
        if (e_hs && !(rsp && qs == 0)) m_q.push_back(e_win);
    endtask

    task automatic settle();
        model_eval();
        @(negedge clk);
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload();
        for (int c = 0; c < NC; c++) begin
            for (int a = 0; a < NA; a++) core_operands[c][a] = $urandom;
            core_op[c]    = OW'(c * 9 + 1 + 16 * ($urandom % 2));
            core_flags[c] = FW'($urandom);
        end
        fpu_rdata  = $urandom;
        fpu_rflags = UW'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        core_req = '0; fpu_gnt = 1'b0; fpu_rvalid = 1'b0; core_rready = '0;
        rand_payload();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_rr = 0; m_pend = -1; m_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_tests++; if (core_gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", core_gnt); end
        n_tests++; if (core_rvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0000", core_rvalid); end
        n_tests++; if (fpu_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", fpu_req); end
        n_tests++; if (fpu_rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b want 0", fpu_rready); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        advance();
    endtask

    task automatic test_bypass();
        do_reset();
        core_req = 4'b0100; fpu_gnt = 1'b1; fpu_rvalid = 1'b1; core_rready = 4'b1111;
        settle();
        n_tests++; if (core_gnt !== 4'b0100) begin n_fail++; $display("FAIL bypass_gnt: got %b want 0100", core_gnt); end
        n_tests++; if (core_rvalid !== 4'b0100) begin n_fail++; $display("FAIL bypass_rvalid: got %b want 0100", core_rvalid); end
        n_tests++; if (fpu_rready !== 1'b1) begin n_fail++; $display("FAIL bypass_rready: got %b want 1", fpu_rready); end
        n_tests++; if (fpu_operands !== core_operands[2]) begin n_fail++; $display("FAIL bypass_operands: got %h want %h", fpu_operands, core_operands[2]); end
        n_tests++; if (core_rdata !== fpu_rdata || core_rflags !== fpu_rflags) begin n_fail++; $display("FAIL bypass_rdata: got %h/%h want %h/%h", core_rdata, core_rflags, fpu_rdata, fpu_rflags); end
        advance();
        core_req = '0; fpu_gnt = 1'b0;
        settle();
        n_tests++; if (core_rvalid !== 4'b0000) begin n_fail++; $display("FAIL bypass_fifo_empty: got %b want 0000", core_rvalid); end
        advance();
        core_req = 4'b1111; fpu_gnt = 1'b1; fpu_rvalid = 1'b0;
        settle();
        n_tests++; if (core_gnt !== 4'b1000) begin n_fail++; $display("FAIL bypass_rr_ptr: got %b want 1000", core_gnt); end
        advance();
    endtask

    task automatic test_round_robin();
        do_reset();
        core_req = 4'b1111; fpu_gnt = 1'b1; core_rready = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            fpu_rvalid = (k >= 2);
            settle();
            n_tests++; if (core_gnt !== (NC'(1) << (k % NC))) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, core_gnt, NC'(1) << (k % NC)); end
            if (k >= 2) begin
                n_tests++; if (core_rvalid !== (NC'(1) << ((k - 2) % NC))) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, core_rvalid, NC'(1) << ((k - 2) % NC)); end
            end
            advance();
        end
        core_req = '0; fpu_gnt = 1'b0; fpu_rvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            n_tests++; if (core_rvalid !== (NC'(1) << k)) begin n_fail++; $display("FAIL rr_drain[%0d]: got %b want %b", k, core_rvalid, NC'(1) << k); end
            advance();
        end
        fpu_rvalid = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        core_req = 4'b0010; fpu_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) core_req = 4'b0011;
            settle();
            n_tests++; if (fpu_req !== 1'b1 || core_gnt !== 4'b0000) begin n_fail++; $display("FAIL lock_wait[%0d]: req %b gnt %b want 1 0000", k, fpu_req, core_gnt); end
            n_tests++; if (fpu_op !== core_op[1] || fpu_operands !== core_operands[1]) begin n_fail++; $display("FAIL lock_winner[%0d]: op %h want %h", k, fpu_op, core_op[1]); end
            advance();
        end
        fpu_gnt = 1'b1;
        settle();
        n_tests++; if (core_gnt !== 4'b0010) begin n_fail++; $display("FAIL lock_gnt: got %b want 0010", core_gnt); end
        advance();
        settle();
        n_tests++; if (core_gnt !== 4'b0001) begin n_fail++; $display("FAIL lock_next: got %b want 0001", core_gnt); end
        advance();
        core_req = '0; fpu_gnt = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        core_rready = 4'b1111; core_req = 4'b1111; fpu_gnt = 1'b1;
        for (int k = 0; k < MI; k++) begin
            settle();
            n_tests++; if (core_gnt !== (NC'(1) << k)) begin n_fail++; $display("FAIL full_fill[%0d]: got %b want %b", k, core_gnt, NC'(1) << k); end
            advance();
        end
        core_req = 4'b1000;
        settle();
        n_tests++; if (fpu_req !== 1'b0 || core_gnt !== 4'b0000) begin n_fail++; $display("FAIL full_block: req %b gnt %b want 0 0000", fpu_req, core_gnt); end
        advance();
        fpu_rvalid = 1'b1;
        settle();
        n_tests++; if (fpu_req !== 1'b0) begin n_fail++; $display("FAIL full_pop_same_cycle: req %b want 0", fpu_req); end
        n_tests++; if (core_rvalid !== 4'b0001 || fpu_rready !== 1'b1) begin n_fail++; $display("FAIL full_pop: rvalid %b rready %b want 0001 1", core_rvalid, fpu_rready); end
        advance();
        fpu_rvalid = 1'b0;
        settle();
        n_tests++; if (fpu_req !== 1'b1 || core_gnt !== 4'b1000) begin n_fail++; $display("FAIL full_resume: req %b gnt %b want 1 1000", fpu_req, core_gnt); end
        advance();
        core_req = '0; fpu_gnt = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        core_req = 4'b0001; fpu_gnt = 1'b1;
        settle();
        n_tests++; if (core_gnt !== 4'b0001) begin n_fail++; $display("FAIL bp_gnt: got %b want 0001", core_gnt); end
        advance();
        core_req = '0; fpu_gnt = 1'b0; fpu_rvalid = 1'b1; core_rready = 4'b1110;
        for (int k = 0; k < 2; k++) begin
            settle();
            n_tests++; if (core_rvalid !== 4'b0001 || fpu_rready !== 1'b0) begin n_fail++; $display("FAIL bp_stall[%0d]: rvalid %b rready %b want 0001 0", k, core_rvalid, fpu_rready); end
            advance();
        end
        core_rready = 4'b0001;
        settle();
        n_tests++; if (core_rvalid !== 4'b0001 || fpu_rready !== 1'b1) begin n_fail++; $display("FAIL bp_release: rvalid %b rready %b want 0001 1", core_rvalid, fpu_rready); end
        advance();
        core_rready = 4'b1111;
        settle();
        n_tests++; if (core_rvalid !== 4'b0000) begin n_fail++; $display("FAIL bp_popped: rvalid %b want 0000", core_rvalid); end
        advance();
        fpu_rvalid = 1'b0;
    endtask

    task automatic test_unexpected();
        do_reset();
        core_req = '0; fpu_rvalid = 1'b1; core_rready = 4'b1111;
        settle();
`ifdef FPU_ARB_ERR_CHECK_EN
        n_tests++; if (fpu_rready !== 1'b1 || core_rvalid !== 4'b0000 || err !== 1'b0) begin n_fail++; $display("FAIL unexp_drop: rready %b rvalid %b err %b want 1 0000 0", fpu_rready, core_rvalid, err); end
        advance();
        fpu_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            core_req = NC'(1 << k);
            fpu_gnt  = 1'b1;
            settle();
            n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL unexp_err_sticky[%0d]: got %b want 1", k, err); end
            advance();
        end
        do_reset();
        settle();
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL unexp_err_clear: got %b want 0", err); end
        core_req = 4'b0010; fpu_gnt = 1'b0;
        advance();
        core_req = 4'b0000;
        settle();
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL lockdrop_early: got %b want 0", err); end
        advance();
        settle();
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL lockdrop_err: got %b want 1", err); end
        advance();
`else
        n_tests++; if (fpu_rready !== 1'b0 || core_rvalid !== 4'b0000) begin n_fail++; $display("FAIL unexp_ignore: rready %b rvalid %b want 0 0000", fpu_rready, core_rvalid); end
        advance();
        settle();
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL unexp_err_tied: got %b want 0", err); end
        advance();
`endif
        fpu_rvalid = 1'b0;
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_payload();
            core_req = NC'($urandom);
            if (m_pend >= 0) core_req[IW'(m_pend)] = 1'b1;
            fpu_gnt     = ($urandom % 3) != 0;
            core_rready = NC'($urandom | $urandom);
            fpu_rvalid  = 1'b0;
            model_eval();
            fpu_rvalid = (e_head >= 0) && ($urandom % 2 == 1);
            settle();
            n_tests++; if (fpu_req !== e_req) begin n_fail++; $display("FAIL rand_req[%0d]: got %b want %b", i, fpu_req, e_req); end
            n_tests++; if (core_gnt !== e_gnt) begin n_fail++; $display("FAIL rand_gnt[%0d]: got %b want %b", i, core_gnt, e_gnt); end
            n_tests++; if (core_rvalid !== e_rvalid) begin n_fail++; $display("FAIL rand_rvalid[%0d]: got %b want %b", i, core_rvalid, e_rvalid); end
            n_tests++; if (fpu_rready !== e_rready) begin n_fail++; $display("FAIL rand_rready[%0d]: got %b want %b", i, fpu_rready, e_rready); end
            n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rand_err[%0d]: got %b want 0", i, err); end
            if (e_req) begin
                n_tests++;
                if (fpu_op !== core_op[IW'(e_win)] || fpu_flags !== core_flags[IW'(e_win)] || fpu_operands !== core_operands[IW'(e_win)]) begin
                    n_fail++; $display("FAIL rand_payload[%0d]: op %h flags %h want %h %h (core %0d)", i, fpu_op, fpu_flags, core_op[IW'(e_win)], core_flags[IW'(e_win)], e_win);
                end
            end
            advance();
        end
        core_req = '0; fpu_gnt = 1'b0; fpu_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_round_robin();
        test_lock();
        test_full();
        test_backpressure();
        test_unexpected();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_core_arbiter.md
Name: fpu_core_arbiter

Overview:
- Many-to-one front end for a shared FPU.
- Arbitrates NB_CORES core request ports onto one FPU master port using round-robin.
- Tracks the core ID of each accepted operation in an in-order ID FIFO and routes every FPU response back to the core that issued it.
- Its FPU-side port uses the same req/gnt + rvalid/rready protocol as the per-core FPU demux slave port, so the demux can be driven from it.

Parameters:
- NB_CORES, 4, number of core request ports (>=2)
- DATA_WIDTH, 32, operand/result width
- NB_ARGS, 3, operands per request
- OPCODE_WIDTH, 6, opcode width
- DSFLAGS_WIDTH, 15, downstream flags width
- USFLAGS_WIDTH, 5, upstream (result) flags width
- MAX_INFLIGHT, 4, ID FIFO depth; power of two, >=2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- core_req_i  in  NB_CORES  per-core request
- core_gnt_o  out  NB_CORES  per-core grant
- core_operands_i  in  NB_CORES x NB_ARGS x DATA_WIDTH  operands
- core_op_i  in  NB_CORES x OPCODE_WIDTH  opcode
- core_flags_i  in  NB_CORES x DSFLAGS_WIDTH  downstream flags
- core_rready_i  in  NB_CORES  per-core response ready
- core_rvalid_o  out  NB_CORES  per-core response valid
- core_rdata_o  out  DATA_WIDTH  result, broadcast to all cores
- core_rflags_o  out  USFLAGS_WIDTH  result flags, broadcast
- fpu_req_o  out  1  request to FPU
- fpu_gnt_i  in  1  FPU grant
- fpu_operands_o  out  NB_ARGS x DATA_WIDTH  winner operands
- fpu_op_o  out  OPCODE_WIDTH  winner opcode
- fpu_flags_o  out  DSFLAGS_WIDTH  winner flags
- fpu_rready_o  out  1  response ready to FPU
- fpu_rvalid_i  in  1  FPU response valid
- fpu_rdata_i  in  DATA_WIDTH  FPU result
- fpu_rflags_i  in  USFLAGS_WIDTH  FPU result flags
- err_o  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge): rr_ptr=0, lock=0, locked_idx=0, FIFO rd/wr pointers and count=0, err=0.
- Outputs after reset: all gnt/rvalid=0, fpu_req_o=0, fpu_rready_o=0.
- Reset mid-operation discards all outstanding IDs; responses arriving afterwards are unexpected.
- Arbitration (combinational):
  - winner = first requesting core at or after rr_ptr, searching in modulo NB_CORES order.
  - If lock=1, winner=locked_idx regardless of other requests.
- Request path:
  - blocked = (count==MAX_INFLIGHT).
  - fpu_req_o = any core_req_i && !blocked.
  - fpu_operands/op/flags driven from the winner; they are don't-care when fpu_req_o=0.
- Grant: core_gnt_o[winner] = fpu_gnt_i && fpu_req_o; all other grants are 0. Combinational, zero added latency.
- Handshake hs = fpu_req_o && fpu_gnt_i. On hs: rr_ptr <= winner+1 (wrapping to 0), lock <= 0.
- Stable request:
  - fpu_req_o && !fpu_gnt_i sets lock=1, locked_idx=winner.
  - The core must hold its request asserted while ungranted.
- Response routing:
  - head = FIFO head entry if count>0.
  - Else, if hs this cycle, head = winner (same-cycle bypass).
  - Else there is no head.
  - With a head: core_rvalid_o[head] = fpu_rvalid_i and fpu_rready_o = core_rready_i[head]; other rvalid bits are 0.
  - core_rdata_o/core_rflags_o = fpu_rdata_i/fpu_rflags_i at all times.
- FIFO update (rsp = fpu_rvalid_i && fpu_rready_o with a valid head):
  - hs && count==0 && rsp: bypass; no push, no pop.
  - hs && rsp && count>0: push winner, pop head; count unchanged.
  - hs only: push, count+1. rsp only: pop, count-1.
  - Pointers wrap modulo MAX_INFLIGHT.
- Full: no new request is issued while count==MAX_INFLIGHT, even if a response pops in the same cycle. This avoids a rvalid->req combinational path.
- Responses are strictly in order; an FPU that reorders is unsupported.

Optional Feature:
- Macro: FPU_ARB_ERR_CHECK_EN.
- Defined:
  - An unexpected response (fpu_rvalid_i with count==0 and no hs) is dropped with fpu_rready_o=1.
  - err_o is set on the next clk and stays set until rst.
  - A core_req_i bit dropping while lock=1 and that core is locked_idx also sets err_o.
- Undefined:
  - err_o tied 0.
  - An unexpected response gets fpu_rready_o=0 and is not forwarded to any core.

Test Plan:
- Reset, then core 2 req with fpu_gnt_i=1 and fpu_rvalid_i=1 in the same cycle -> core_gnt_o=4'b0100, core_rvalid_o=4'b0100, count stays 0, rr_ptr=3.
- All 4 cores req continuously, fpu_gnt_i=1, rvalid 2 cycles after each grant -> grant order 0,1,2,3,0; each response is delivered to the matching core.
- Core 1 req, fpu_gnt_i=0 for 3 cycles while core 0 also raises req -> core 1 stays the winner (lock); core_gnt_o=4'b0010 when gnt rises.
- Issue 4 granted ops with no responses (MAX_INFLIGHT=4) -> fpu_req_o=0 with core 3 requesting; after one rvalid/rready, fpu_req_o=1 on the next cycle.
- Response to core 0 held with core_rready_i[0]=0 for 2 cycles -> fpu_rready_o=0 and FIFO head unchanged; pops the cycle rready=1.
- With FPU_ARB_ERR_CHECK_EN: fpu_rvalid_i=1 with count=0 and no req -> fpu_rready_o=1, all core_rvalid_o=0, err_o=1 on the next cycle and it stays 1 until rst.
